pal_scan_ctrl: RTL and testbench

PAL_SCAN_CTRL -- requirements
Module: pal_scan_ctrl

---
 rtl/pal_pkg.sv | 16 +
 rtl/pal3_det.sv | 34 +++
 rtl/pal_scan_ctrl.sv | 110 +++++++++++
 tb/tb_pal_scan_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
// rtl/pal_pkg.sv - shared state encoding and width helper for the palindrome scanner
package pal_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pal_state_t;

    // A W-bit word has at most W-2 three-bit windows; this width holds that count.
    function automatic int pal_cnt_width(input int w);
        return $clog2(w - 1);
    endfunction

endpackage

// File: rtl/pal3_det.sv
// rtl/pal3_det.sv - registered 3-bit palindromic window detector over a serial bit stream
module pal3_det (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    logic       prev1;
    logic       prev2;
    logic [1:0] seen;

    // seen saturates at 2: once two bits of history exist every new bit closes a window.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev1 <= 1'b0;
            prev2 <= 1'b0;
            seen  <= 2'd0;
            hit   <= 1'b0;
        end else if (en) begin
            hit   <= (seen == 2'd2) && (bit_in == prev2);
            prev2 <= prev1;
            prev1 <= bit_in;
            if (seen != 2'd2) begin
                seen <= seen + 2'd1;
            end
        end else begin
            hit <= 1'b0;
        end
    end

endmodule

// File: rtl/pal_scan_ctrl.sv
// rtl/pal_scan_ctrl.sv - counts 3-bit palindromic windows in each accepted word, MSB first
module pal_scan_ctrl
    import pal_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = pal_cnt_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_any,
    output logic          busy
);

    localparam int BW = $clog2(W);

    pal_state_t    state;
    pal_state_t    state_nxt;
    logic [W-1:0]  shreg;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] hit_cnt;
    logic          accept;
    logic          det_en;
    logic          det_hit;
    logic          last_bit;

    assign accept   = in_valid && (state == IDLE);
    assign det_en   = (state == SHIFT);
    assign last_bit = (bit_cnt == BW'(W - 1));

    pal3_det u_det (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (det_en),
        .bit_in (shreg[W-1]),
        .hit    (det_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DRAIN;
                end
            end
            // One extra cycle so the hit registered on the final bit is counted.
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            hit_cnt <= '0;
        end else if (accept) begin
            shreg   <= in_data;
            bit_cnt <= '0;
            hit_cnt <= '0;
        end else begin
            if (state == SHIFT) begin
                shreg   <= {shreg[W-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (det_hit && (state == SHIFT || state == DRAIN)) begin
                hit_cnt <= hit_cnt + CW'(1);
            end
        end
    end

    assign out_count = hit_cnt;
    assign out_any   = (hit_cnt != '0);

endmodule

// File: tb/tb_pal_scan_ctrl.sv
// tb/tb_pal_scan_ctrl.sv - directed-vector bench for pal_scan_ctrl at W=8
module tb_pal_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          out_any;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pal_scan_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_any   (out_any),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accept one word, wait for out_valid (bounded), return edges from accept to out_valid.
    task automatic send_word(input logic [W-1:0] data, output int lat);
        @(negedge clk);
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_word(input string tag, input logic [W-1:0] data,
                            input int exp_cnt, input logic chk_lat);
        int lat;
        send_word(data, lat);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
        check_val({tag, "_any"}, 32'(out_any), 32'(exp_cnt != 0));
        if (chk_lat) begin
            check_val({tag, "_latency"}, 32'(lat), 32'(W + 1));
        end
        release_result();
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_count", 32'(out_count), 32'd0);
        check_val("rst_out_any", 32'(out_any), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);

        run_word("ff", 8'hFF, 6, 1'b1);
        run_word("00", 8'h00, 6, 1'b0);
        run_word("cc", 8'hCC, 0, 1'b0);
        run_word("aa", 8'hAA, 6, 1'b0);
        run_word("5a", 8'h5A, 4, 1'b1);
        run_word("01", 8'h01, 5, 1'b0);
        run_word("00b", 8'h00, 6, 1'b0);

        // Hold off downstream in DONE and poke in_valid.
        send_word(8'h5A, lat);
        check_val("hold_entry_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 8'hFF;
            @(posedge clk);
            @(negedge clk);
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_count", 32'(out_count), 32'd4);
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_data  = '0;
        release_result();
        check_val("hold_back_idle", 32'(in_ready), 32'd1);
        check_val("hold_no_extra", 32'(out_valid), 32'd0);

        // Reset during the 4th SHIFT cycle.
        @(negedge clk);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_out_count", 32'(out_count), 32'd0);
        check_val("mid_rst_out_any", 32'(out_any), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_no_valid", 32'(out_valid), 32'd0);
        run_word("post_rst_ff", 8'hFF, 6, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
